// File: rtl/pe_result_collector_if.sv
// rtl/pe_result_collector_if.sv - PE-array frame input stream and tagged result-word output stream
interface pe_result_collector_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NPE        = 16
);
  logic [DATA_WIDTH*NPE-1:0] pe_result_flat;
  logic                      pe_result_valid;
  logic                      pe_result_ready;
  logic [31:0]               res_data;
  logic                      res_valid;
  logic                      res_last;
  logic                      res_ready;

  modport slave (
    input  pe_result_flat, pe_result_valid, res_ready,
    output pe_result_ready, res_data, res_valid, res_last
  );

  modport master (
    output pe_result_flat, pe_result_valid, res_ready,
    input  pe_result_ready, res_data, res_valid, res_last
  );
endinterface

// File: rtl/pe_result_collector.sv
// rtl/pe_result_collector.sv - snapshots a PE-array frame and serialises tagged lane results through a FIFO
module pe_result_collector #(
  parameter int DATA_WIDTH = 16,
  parameter int PE_ROWS    = 4,
  parameter int PE_COLS    = 4,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pe_result_collector_if.slave   bus,
  output logic [7:0]             frame_count,
  output logic                   busy
);
  localparam int NPE = PE_ROWS * PE_COLS;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;

  typedef enum logic {S_IDLE, S_DRAIN} state_t;

  state_t                    state, state_next;
  logic [DATA_WIDTH*NPE-1:0] snap;
  logic [7:0]                frame_tag;
  logic [4:0]                idx;

  logic [32:0]               mem [FIFO_DEPTH];
  logic [AW-1:0]             wr_ptr, rd_ptr;
  logic [CW-1:0]             count;

  logic                      accept, push, pop, lane_last, fifo_full;
  logic [15:0]               lane16;
  logic [32:0]               push_word;

  assign fifo_full = (count == CW'(FIFO_DEPTH));
  assign lane_last = (idx == 5'(NPE - 1));
  assign pop       = (count != '0) && bus.res_ready;

  always_comb begin
    lane16                   = '0;
    lane16[DATA_WIDTH-1:0]   = snap[int'(idx)*DATA_WIDTH +: DATA_WIDTH];
  end

  // Bit 32 carries the end-of-frame flag alongside the 32-bit result word.
  assign push_word = {lane_last, lane16, 3'b000, frame_tag, idx};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    push       = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.pe_result_valid) begin
          accept     = 1'b1;
          state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Fullness is judged at the start of the cycle; a same-cycle pop does not free a slot.
        if (!fifo_full) begin
          push = 1'b1;
          if (lane_last) state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap        <= '0;
      frame_tag   <= '0;
      idx         <= '0;
      frame_count <= '0;
    end else if (accept) begin
      snap      <= bus.pe_result_flat;
      frame_tag <= frame_count;
      idx       <= '0;
    end else if (push) begin
      idx <= idx + 5'd1;
      if (lane_last) frame_count <= frame_count + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign bus.pe_result_ready = (state == S_IDLE);
  assign bus.res_valid       = (count != '0);
  assign bus.res_data        = bus.res_valid ? mem[rd_ptr][31:0] : 32'd0;
  assign bus.res_last        = bus.res_valid ? mem[rd_ptr][32]   : 1'b0;
  assign busy                = (state == S_DRAIN) || (count != '0);
endmodule

// File: tb/tb_pe_result_collector.sv
// tb/tb_pe_result_collector.sv - randomized scoreboard bench for pe_result_collector
module tb_pe_result_collector;
  localparam int DW    = 16;
  localparam int NPE   = 16;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] frame_count;
  logic       busy;

  always #5 clk = ~clk;

  pe_result_collector_if #(.DATA_WIDTH(DW), .NPE(NPE)) bus ();

  pe_result_collector #(
    .DATA_WIDTH(DW), .PE_ROWS(4), .PE_COLS(4), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .frame_count(frame_count), .busy(busy)
  );

  int          checks = 0;
  int          errors = 0;
  logic [32:0] exp_q[$];
  int          tag_model = 0;
  bit          rand_mode = 1'b0;
  bit          fixed_ready = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [32:0] model_word(input int lane_val, input int tag, input int i);
    logic [32:0] w;
    w[31:0] = (32'(lane_val) & 32'hFFFF) * 32'd65536 + 32'(tag % 256) * 32'd32 + 32'(i);
    w[32]   = (i == NPE - 1);
    return w;
  endfunction

  // Consumer ready: random in stress mode, otherwise a level set by the stimulus.
  always @(posedge clk) begin
    #1;
    bus.res_ready = rand_mode ? ($urandom_range(3) != 0) : fixed_ready;
  end

  logic        prev_stall = 1'b0;
  logic [32:0] prev_word;

  always @(negedge clk) begin
    logic [32:0] w;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) check("hold_stable", {bus.res_last, bus.res_data}, prev_word);
      if (!bus.res_valid) begin
        check("empty_zero", {bus.res_last, bus.res_data}, 33'd0);
      end else if (bus.res_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %0h expected none", {bus.res_last, bus.res_data});
        end else begin
          w = exp_q.pop_front();
          check("res_word", {bus.res_last, bus.res_data}, w);
        end
      end
      prev_stall = bus.res_valid && !bus.res_ready;
      prev_word  = {bus.res_last, bus.res_data};
    end
  end

  task automatic send_frame(input logic [DW*NPE-1:0] lanes);
    bit ok;
    ok = 1'b0;
    bus.pe_result_flat  = lanes;
    bus.pe_result_valid = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (bus.pe_result_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      check("accept_timeout", 64'd0, 64'd1);
      bus.pe_result_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    bus.pe_result_valid = 1'b0;
    for (int i = 0; i < NPE; i++) exp_q.push_back(model_word(int'(lanes[i*DW +: DW]), tag_model, i));
    tag_model = (tag_model + 1) % 256;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("idle_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW*NPE-1:0] ramp(input int base);
    logic [DW*NPE-1:0] l;
    for (int i = 0; i < NPE; i++) l[i*DW +: DW] = 16'(base + i);
    return l;
  endfunction

  initial begin
    logic [DW*NPE-1:0] lanes;
    int low_cycles;
    bus.pe_result_valid = 1'b0;
    bus.pe_result_flat  = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", bus.pe_result_ready, 1);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_res_data", bus.res_data, 0);
    check("rst_frame_count", frame_count, 0);
    check("rst_busy", busy, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    fixed_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    send_frame(ramp(16'h1000));
    low_cycles = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (bus.pe_result_ready) break;
      low_cycles++;
    end
    check("ready_low_cycles", low_cycles, NPE);
    @(posedge clk);
    #1;
    wait_idle();
    check("frame_count_single", frame_count, 1);

    fixed_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    send_frame(ramp(16'hA000));
    send_frame(ramp(16'hB000));
    repeat (30) @(posedge clk);
    #1;
    check("stall_busy", busy, 1);
    check("stall_ready_low", bus.pe_result_ready, 0);
    check("stall_res_valid", bus.res_valid, 1);
    check("stall_count_full", dut.count, DEPTH);

    fixed_ready = 1'b1;
    @(posedge clk);
    #2 fixed_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("full_pop_count", dut.count, DEPTH - 1);
    @(negedge clk);
    check("push_resume_count", dut.count, DEPTH);
    @(posedge clk);
    #1 fixed_ready = 1'b1;
    wait_idle();
    check("frame_count_bp", frame_count, 3);

    rand_mode = 1'b1;
    for (int k = 0; k < 257; k++) begin
      for (int i = 0; i < NPE; i++) lanes[i*DW +: DW] = 16'($urandom);
      send_frame(lanes);
      if (tag_model == 0) begin
        wait_idle();
        check("frame_count_wrap", frame_count, 0);
      end
    end
    wait_idle();
    check("frame_count_after_wrap", frame_count, 8'(tag_model));

    rand_mode   = 1'b0;
    fixed_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    send_frame(ramp(16'h6000));
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    exp_q.delete();
    tag_model = 0;
    @(negedge clk);
    check("midrst_res_valid", bus.res_valid, 0);
    check("midrst_ready", bus.pe_result_ready, 1);
    check("midrst_busy", busy, 0);
    check("midrst_frame_count", frame_count, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    send_frame(ramp(16'h7000));
    wait_idle();
    check("frame_count_post_rst", frame_count, 1);
    check("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
